sc_bitstream_gen: RTL and testbench

//  Binary-to-stochastic front end for sc_serial_mul.
//  - Captures NUM_INPUTS unsigned DATA_WIDTH-bit operands on a start handshake.
//  - Emits one unipolar bitstream per operand, 2**DATA_WIDTH beats long; beat
//    i is bit = (x_i > r_i[t]).
//  - Each operand has its own full-period de Bruijn RNG with a distinct seed, so

---
 rtl/sc_pkg.sv | 39 +++
 rtl/sc_debruijn_rng.sv | 43 ++++
 rtl/sc_bitstream_gen.sv | 91 +++++++++
 tb/tb_sc_bitstream_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing bitstream front end.
package sc_pkg;

    typedef enum logic {SC_IDLE, SC_RUN} sc_state_t;

    localparam int unsigned SC_MIN_WIDTH = 3;
    localparam int unsigned SC_MAX_WIDTH = 16;

    // Maximal-length Fibonacci tap masks; bit k set means state bit k feeds back.
    function automatic logic [15:0] sc_lfsr_taps(input int unsigned width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int unsigned sc_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic int unsigned sc_seed(input int unsigned base, input int unsigned stride,
                                            input int unsigned idx, input int unsigned width);
        return (base + idx * stride) % sc_len(width);
    endfunction

endpackage

// File: rtl/sc_debruijn_rng.sv
// Full-period de Bruijn sequence generator: an LFSR with the all-zero state spliced in,
// so every WIDTH-bit value appears exactly once per 2**WIDTH steps.
module sc_debruijn_rng
    import sc_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] rnd
);

    localparam logic [15:0]      TapsFull = sc_lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] Taps     = TapsFull[WIDTH-1:0];

    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic             feedback;

    always_comb begin
        // The NOR term routes 100..0 -> 0 -> 00..1, extending the period by one.
        feedback = (^(rnd_q & Taps)) ^ (rnd_q[WIDTH-2:0] == '0);
        rnd_d    = rnd_q;
        if (load) begin
            rnd_d = SEED;
        end else if (step) begin
            rnd_d = {rnd_q[WIDTH-2:0], feedback};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_q <= SEED;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign rnd = rnd_q;

endmodule

// File: rtl/sc_bitstream_gen.sv
// Binary-to-stochastic converter: latches operands on start and emits one unipolar
// bitstream per operand, 2**DATA_WIDTH beats long, with valid/ready flow control.
module sc_bitstream_gen
    import sc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned NUM_INPUTS  = 2,
    parameter int unsigned SEED_BASE   = 1,
    parameter int unsigned SEED_STRIDE = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   ready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  bin_data_in,
    input  logic                                   out_ready,
    output logic                                   sc_valid,
    output logic [NUM_INPUTS-1:0]                  sc_bit_out,
    output logic                                   sc_last,
    output logic                                   done
);

    localparam int unsigned          N        = sc_len(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] LastBeat = DATA_WIDTH'(N - 1);

    sc_state_t                              state_q;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  x_q;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  rnd;
    logic [DATA_WIDTH-1:0]                  cnt_q;
    logic                                   done_q;
    logic                                   running;
    logic                                   accept;
    logic                                   xfer;

    assign running = (state_q == SC_RUN);
    assign accept  = start & ~running;
    assign xfer    = running & out_ready;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        localparam logic [DATA_WIDTH-1:0] Seed =
            DATA_WIDTH'(sc_seed(SEED_BASE, SEED_STRIDE, i, DATA_WIDTH));

        sc_debruijn_rng #(
            .WIDTH (DATA_WIDTH),
            .SEED  (Seed)
        ) u_rng (
            .clk  (clk),
            .rst  (rst),
            .load (accept),
            .step (xfer),
            .rnd  (rnd[i])
        );

        assign sc_bit_out[i] = running & (x_q[i] > rnd[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SC_IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SC_IDLE: begin
                    if (start) begin
                        x_q     <= bin_data_in;
                        cnt_q   <= '0;
                        state_q <= SC_RUN;
                    end
                end
                SC_RUN: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastBeat) begin
                            state_q <= SC_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ready    = ~running;
    assign sc_valid = running;
    assign sc_last  = running & (cnt_q == LastBeat);
    assign done     = done_q;

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Scoreboard bench for sc_bitstream_gen at DATA_WIDTH=4, two operands, default seeds (1, 6).
module tb_sc_bitstream_gen;

    localparam logic [3:0] Seed0 = 4'd1;
    localparam logic [3:0] Seed1 = 4'd6;

    typedef struct packed {
        logic [3:0] x0;
        logic [3:0] x1;
    } run_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            out_ready = 1'b1;
    logic [1:0][3:0] bin = '0;
    logic            ready, sc_valid, sc_last, done;
    logic [1:0]      sc_bit_out;

    int n_checks = 0;
    int n_fail = 0;
    int runs_done = 0;

    run_t       run_q[$];
    logic [1:0] beat_q[$];

    // Monitor state
    int          bidx = 0;
    int          bidx_done = 0;
    int          pc0 = 0;
    int          pc1 = 0;
    logic        run_act = 1'b0;
    logic        prev_last = 1'b0;
    logic        prev_stall = 1'b0;
    logic [2:0]  held = '0;
    logic [15:0] cur0 = '0, cur1 = '0, done_s0 = '0, done_s1 = '0;
    run_t        cur;

    sc_bitstream_gen #(
        .DATA_WIDTH  (4),
        .NUM_INPUTS  (2),
        .SEED_BASE   (1),
        .SEED_STRIDE (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready),
        .bin_data_in (bin),
        .out_ready   (out_ready),
        .sc_valid    (sc_valid),
        .sc_bit_out  (sc_bit_out),
        .sc_last     (sc_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            run_act    = 1'b0;
            bidx       = 0;
            pc0        = 0;
            pc1        = 0;
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_last || done) check("done_pulse", done, prev_last);
            if (done) begin
                check("ready_at_done", ready, 1'b1);
                check("run_q_nonempty", run_q.size() > 0, 1'b1);
                if (run_q.size() > 0) begin
                    cur = run_q.pop_front();
                    check("popcount0", pc0, cur.x0);
                    check("popcount1", pc1, cur.x1);
                end
                check("beats", bidx_done, 16);
                done_s0 = cur0;
                done_s1 = cur1;
                runs_done++;
            end
            prev_last = 1'b0;
            if (run_act) check("valid_in_run", {sc_valid, ready}, 2'b10);
            if (prev_stall && sc_valid) check("stall_hold", {sc_last, sc_bit_out}, held);
            prev_stall = sc_valid && !out_ready;
            held = {sc_last, sc_bit_out};
            if (sc_valid && out_ready) begin
                check("last_flag", sc_last, bidx == 15);
                if (bidx == 0 && run_q.size() > 0) begin
                    check("first_bit0", sc_bit_out[0], run_q[0].x0 > Seed0);
                    check("first_bit1", sc_bit_out[1], run_q[0].x1 > Seed1);
                end
                if (beat_q.size() > 0) check("beat_seq", sc_bit_out, beat_q.pop_front());
                if (bidx < 16) begin
                    cur0[bidx] = sc_bit_out[0];
                    cur1[bidx] = sc_bit_out[1];
                end
                pc0 += int'(sc_bit_out[0]);
                pc1 += int'(sc_bit_out[1]);
                bidx++;
                if (sc_last) begin
                    prev_last = 1'b1;
                    bidx_done = bidx;
                    run_act   = 1'b0;
                end
            end
            if (start && ready) begin
                run_act = 1'b1;
                bidx    = 0;
                pc0     = 0;
                pc1     = 0;
            end
        end
    end

    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input int stall_pct);
        int n0;
        int cyc;
        n0 = runs_done;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = {b, a};
        run_q.push_back(run_t'{x0: a, x1: b});
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (runs_done == n0 && cyc < 200) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        check("run_complete", runs_done != n0, 1'b1);
    endtask

    logic [15:0] s1_0, s1_1, a0, a1;
    int          n0, cyc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_outs", {sc_valid, sc_last, sc_bit_out, done}, 5'd0);
        rst = 1'b1;

        run_one(4'd5, 4'd11, 0);
        s1_0 = done_s0;
        s1_1 = done_s1;

        run_one(4'd0, 4'd15, 0);
        check("s2_stream0_zero", done_s0, 16'h0000);

        run_one(4'd8, 4'd8, 0);
        a0 = done_s0;
        a1 = done_s1;
        check("s3_decorrelated", a0 != a1, 1'b1);
        run_one(4'd8, 4'd8, 0);
        check("s3_repeat0", done_s0, a0);
        check("s3_repeat1", done_s1, a1);

        for (int k = 0; k < 16; k++) beat_q.push_back({s1_1[k], s1_0[k]});
        run_one(4'd5, 4'd11, 40);
        check("s4_beats_left", beat_q.size(), 0);
        beat_q.delete();

        // Abort a run with reset while beat 7 is presented.
        @(posedge clk); #1;
        start = 1'b1;
        bin   = {4'd11, 4'd5};
        run_q.push_back(run_t'{x0: 4'd5, x1: 4'd11});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("s5_abort_outs", {sc_valid, sc_last, sc_bit_out, done}, 5'd0);
        check("s5_abort_ready", ready, 1'b1);
        run_q.delete();
        n0 = runs_done;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("s5_no_done", runs_done, n0);
        check("s5_ready_after", ready, 1'b1);
        run_one(4'd3, 4'd12, 0);

        // Start held through a run with operands changed mid-run.
        n0 = runs_done;
        @(posedge clk); #1;
        start = 1'b1;
        bin   = {4'd11, 4'd5};
        run_q.push_back(run_t'{x0: 4'd5, x1: 4'd11});
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 bin = {4'd9, 4'd2};
        run_q.push_back(run_t'{x0: 4'd2, x1: 4'd9});
        cyc = 0;
        while (runs_done < n0 + 1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("s6_first_done", runs_done, n0 + 1);
        cyc = 0;
        while (runs_done < n0 + 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("s6_second_done", runs_done, n0 + 2);
        check("s6_queue_drained", run_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
